// File: rtl/delta_decimator.sv
// Delta-modulator bitstream decimator: saturating (optionally adaptive) reconstruction plus a DECIM-sample average.
// Latency: acc_out updates one cycle after an accepted bit; a sample reaches the FIFO head one cycle after the DECIM-th bit.
// Backpressure: 2-deep output FIFO on sample_valid/sample_ready; a sample arriving while full without a pop is dropped and flags overflow.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   en                processing enable; gates bit acceptance only (FIFO pop and clear_ovf stay live)
//   bit_valid, bit_in delta bit stream (1 = up, 0 = down)
//   adaptive          1 = run-length adaptive step, 0 = fixed STEP_MIN
//   acc_out           registered reconstruction value
//   sample_data/valid/ready  decimated sample stream (FIFO head)
//   overflow, clear_ovf      sticky drop flag and its clear

module delta_decimator #(
    parameter int OUT_W    = 8,
    parameter int DECIM    = 16,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             adaptive,
    output logic [OUT_W-1:0] acc_out,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int LOG_D = $clog2(DECIM);
    localparam int SUM_W = OUT_W + LOG_D;

    localparam logic [OUT_W-1:0] ACC_MID    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W:0]   ACC_MAX    = {1'b0, {OUT_W{1'b1}}};
    localparam logic [OUT_W-1:0] STEP_MIN_V = OUT_W'(STEP_MIN);
    localparam logic [OUT_W-1:0] STEP_MAX_V = OUT_W'(STEP_MAX);
    localparam logic [LOG_D-1:0] CNT_LAST   = LOG_D'(DECIM - 1);
    localparam logic [LOG_D-1:0] CNT_ONE    = LOG_D'(1);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] step;
    logic [1:0]       run_len;
    logic             last_bit;
    logic [SUM_W-1:0] sum;
    logic [LOG_D-1:0] count;

    logic             accept;
    logic [OUT_W-1:0] step_cur;
    logic [OUT_W:0]   acc_up_ext;
    logic [OUT_W-1:0] acc_new;
    logic             flip;
    logic [1:0]       run_inc;
    logic [1:0]       run_nxt;
    logic [OUT_W-1:0] step_half;
    logic [OUT_W:0]   step_dbl;
    logic [OUT_W-1:0] step_nxt;
    logic [SUM_W-1:0] sum_tot;
    logic             last;
    logic             push_vld;
    logic             push_rdy;
    logic [OUT_W-1:0] push_dat;
    logic             drop;

    assign accept = bit_valid & en;

    // The step used for this bit is the one held before adaptation; fixed mode
    // ignores whatever the register holds.
    assign step_cur = adaptive ? step : STEP_MIN_V;

    // Saturating accumulate: one extra bit catches the carry on the way up,
    // an explicit compare prevents borrow on the way down.
    always_comb begin
        acc_up_ext = {1'b0, acc} + {1'b0, step_cur};
        acc_new    = acc;
        if (bit_in) begin
            acc_new = (acc_up_ext > ACC_MAX) ? {OUT_W{1'b1}} : acc_up_ext[OUT_W-1:0];
        end else begin
            acc_new = (acc < step_cur) ? '0 : acc - step_cur;
        end
    end

    // Run-length step adaptation: a direction change halves the step and
    // restarts the run; a run reaching 3 doubles it (capped).
    always_comb begin
        flip      = (run_len != 2'd0) && (bit_in != last_bit);
        run_inc   = (run_len == 2'd3) ? 2'd3 : run_len + 2'd1;
        run_nxt   = flip ? 2'd1 : run_inc;
        step_half = step >> 1;
        step_dbl  = {1'b0, step} << 1;
        step_nxt  = step;
        if (!adaptive) begin
            step_nxt = STEP_MIN_V;
        end else if (flip) begin
            step_nxt = (step_half < STEP_MIN_V) ? STEP_MIN_V : step_half;
        end else if (run_inc == 2'd3) begin
            step_nxt = (step_dbl > {1'b0, STEP_MAX_V}) ? STEP_MAX_V : step_dbl[OUT_W-1:0];
        end
    end

    // The DECIM-th value is folded in combinationally so the average can be
    // pushed on the same edge that accepts the bit.
    assign sum_tot  = sum + {{LOG_D{1'b0}}, acc_new};
    assign last     = (count == CNT_LAST);
    assign push_vld = accept & last;
    assign push_dat = sum_tot[SUM_W-1:LOG_D];
    assign drop     = push_vld & ~push_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= ACC_MID;
            step     <= STEP_MIN_V;
            run_len  <= 2'd0;
            last_bit <= 1'b0;
            sum      <= '0;
            count    <= '0;
        end else if (accept) begin
            acc      <= acc_new;
            step     <= step_nxt;
            run_len  <= run_nxt;
            last_bit <= bit_in;
            if (last) begin
                sum   <= '0;
                count <= '0;
            end else begin
                sum   <= sum_tot;
                count <= count + CNT_ONE;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign acc_out = acc;

    fifo #(
        .W     (OUT_W),
        .DEPTH (2)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push_vld),
        .in_rdy  (push_rdy),
        .in_dat  (push_dat),
        .out_vld (sample_valid),
        .out_rdy (sample_ready),
        .out_dat (sample_data)
    );

endmodule

// Generic in-order FIFO with valid/ready on both sides.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: in_rdy stays high when full if the head is being popped that cycle.
//
// Ports: clk, rst (sync active-high); in_vld/in_rdy/in_dat write side;
//        out_vld/out_rdy/out_dat read side (out_dat is the head entry, zero after reset).

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign out_vld = (cnt != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld & out_rdy;
    assign in_rdy  = (cnt != CNT_FULL) | out_rdy;
    assign push    = in_vld & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_delta_decimator.sv
// Directed bench for delta_decimator with hand-computed expected values.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at that same point.
// Popped samples are recorded by a monitor on the rising edge.

module tb_delta_decimator;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       bit_valid;
    logic       bit_in;
    logic       adaptive;
    logic [7:0] acc_out;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       overflow;
    logic       clear_ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pops [$];

    always #5 clk = ~clk;

    delta_decimator #(
        .OUT_W    (8),
        .DECIM    (16),
        .STEP_MIN (1),
        .STEP_MAX (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .adaptive     (adaptive),
        .acc_out      (acc_out),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    always @(posedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            pops.push_back(sample_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pops.delete();
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_run(input logic b, input int n);
        for (int k = 0; k < n; k++) send_bit(b);
    endtask

    // Alternating 1,0,1,0,...
    task automatic send_alt(input int n);
        for (int k = 0; k < n; k++) send_bit(!k[0]);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_vld"}, sample_valid, 1);
        check({tag, "_dat"}, sample_data, exp);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int   exp3 [7];
        logic wrapped;
        logic [7:0] prev;

        rst          = 1'b1;
        en           = 1'b1;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        adaptive     = 1'b0;
        sample_ready = 1'b0;
        clear_ovf    = 1'b0;
        tick();
        do_reset();

        check("rst_acc", acc_out, 128);
        check("rst_vld", sample_valid, 0);
        check("rst_dat", sample_data, 0);
        check("rst_ovf", overflow, 0);

        // 1: fixed step, alternating bits -> 129/128 toggling, sample 128
        for (int i = 0; i < 16; i++) begin
            send_bit(!i[0]);
            if (i == 0)  check("t1_acc_b1", acc_out, 129);
            if (i == 1)  check("t1_acc_b2", acc_out, 128);
            if (i == 14) check("t1_vld_b15", sample_valid, 0);
        end
        check("t1_vld_b16", sample_valid, 1);
        check("t1_dat", sample_data, 128);
        check("t1_ovf", overflow, 0);

        // 2: fixed step, 16 ones -> acc 129..144, sample 2184>>4 = 136
        do_reset();
        send_run(1'b1, 16);
        check("t2_acc", acc_out, 144);
        check("t2_vld", sample_valid, 1);
        check("t2_dat", sample_data, 136);

        // 3: adaptive, 1,1,1,1,1,0,0 -> steps 1,1,1,2,4 then 8 on the first 0, then 4
        do_reset();
        adaptive = 1'b1;
        exp3 = '{129, 130, 131, 133, 137, 129, 125};
        for (int i = 0; i < 7; i++) begin
            send_bit(i < 5);
            check($sformatf("t3_acc_b%0d", i + 1), acc_out, exp3[i]);
        end

        // 4: adaptive saturation both ways, consumer always ready
        do_reset();
        sample_ready = 1'b1;
        wrapped = 1'b0;
        prev = 8'd128;
        for (int i = 0; i < 300; i++) begin
            send_bit(1'b1);
            if (acc_out < prev) wrapped = 1'b1;
            prev = acc_out;
        end
        check("t4_acc_hi", acc_out, 255);
        check("t4_nowrap_hi", wrapped, 0);
        check("t4_npop_hi", pops.size(), 18);
        if (pops.size() >= 2) begin
            check("t4_first", pops[0], 189);
            check("t4_second", pops[1], 255);
            check("t4_last_hi", pops[pops.size() - 1], 255);
        end
        for (int i = 0; i < 300; i++) begin
            send_bit(1'b0);
            if (i == 0) check("t4_first_down", acc_out, 239);
            if (acc_out > prev) wrapped = 1'b1;
            prev = acc_out;
        end
        check("t4_acc_lo", acc_out, 0);
        check("t4_nowrap_lo", wrapped, 0);
        check("t4_npop_lo", pops.size(), 37);
        if (pops.size() > 0) check("t4_last_lo", pops[pops.size() - 1], 0);
        sample_ready = 1'b0;

        // 5: backpressure, drop, in-order pops, overflow clear behaviour
        do_reset();
        adaptive = 1'b0;
        send_alt(16);                 // 128
        send_run(1'b1, 16);           // 129..144 -> 136
        check("t5_ovf_full", overflow, 0);
        send_alt(16);                 // 145/144 -> 144, dropped
        check("t5_ovf_drop", overflow, 1);
        pop_expect("t5_pop0", 128);
        pop_expect("t5_pop1", 136);
        check("t5_empty", sample_valid, 0);
        check("t5_ovf_sticky", overflow, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("t5_ovf_clr", overflow, 0);

        // push and pop on the same edge while full: no drop
        send_run(1'b1, 32);
        send_run(1'b1, 15);
        sample_ready = 1'b1;
        send_bit(1'b1);
        sample_ready = 1'b0;
        check("t5_pushpop_ovf", overflow, 0);
        check("t5_pushpop_vld", sample_valid, 1);

        // drop coinciding with clear: flag stays set
        send_run(1'b1, 15);
        clear_ovf = 1'b1;
        send_bit(1'b1);
        clear_ovf = 1'b0;
        check("t5_clr_vs_drop", overflow, 1);

        // 6: reset mid-stream discards partial sum
        do_reset();
        send_run(1'b1, 10);
        do_reset();
        check("t6_acc_rst", acc_out, 128);
        check("t6_vld_rst", sample_valid, 0);
        send_run(1'b1, 6);
        check("t6_vld_6", sample_valid, 0);
        send_run(1'b1, 10);
        check("t6_vld_16", sample_valid, 1);
        check("t6_dat_16", sample_data, 136);

        // en low holds all processing state
        do_reset();
        send_run(1'b1, 8);
        en        = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        repeat (3) tick();
        bit_valid = 1'b0;
        check("t6_en_hold", acc_out, 136);
        en = 1'b1;
        send_run(1'b1, 7);
        check("t6_en_vld15", sample_valid, 0);
        send_bit(1'b1);
        check("t6_en_vld16", sample_valid, 1);
        check("t6_en_dat", sample_data, 136);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
